// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-TOY core.
// Tracks the destinations held in ID/EX, EX/MEM and MEM/WB in shadow slots.
// Uses those slots to drive PC/IF-ID enables, IF/ID flush, ID/EX bubble
// and the EX-stage operand forwarding selects.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush counters;
// without it STALL_CNT and FLUSH_CNT are tied to zero.
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ID_VALID,
  input  logic              ID_RE1,
  input  logic              ID_RE2,
  input  logic [ADDR_W-1:0] ID_RA1,
  input  logic [ADDR_W-1:0] ID_RA2,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic [ADDR_W-1:0] ID_WA,
  input  logic              BR_TAKEN,
  input  logic              MEM_BUSY,
  output logic              PC_EN,
  output logic              IFID_EN,
  output logic              IFID_FLUSH,
  output logic              IDEX_BUBBLE,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  // EX slot keeps the source operands too, since forwarding is resolved there.
  // The load flag is only needed while the producer sits in EX, so the MEM
  // and WB slots carry just valid/regwrite/destination.
  logic              exValid_q, exRegWrite_q, exMemRead_q, exRe1_q, exRe2_q;
  logic [ADDR_W-1:0] exWa_q, exRa1_q, exRa2_q;
  logic              memValid_q, memRegWrite_q;
  logic [ADDR_W-1:0] memWa_q;
  logic              wbValid_q, wbRegWrite_q;
  logic [ADDR_W-1:0] wbWa_q;

  logic       loadUse;
  logic       pcEn, ifidEn, ifidFlush, idexBubble;
  logic [1:0] fwdA, fwdB;

  // Detect a load in EX whose destination is read by the instruction in ID.
  always_comb begin
    loadUse = ID_VALID & exValid_q & exMemRead_q & exRegWrite_q &
              ((ID_RE1 & (ID_RA1 == exWa_q)) | (ID_RE2 & (ID_RA2 == exWa_q)));
  end

  // Pipeline sequencing: memory freeze beats redirect, redirect beats stall.
  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    if (MEM_BUSY) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
    end else if (BR_TAKEN) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (loadUse) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      idexBubble = 1'b1;
    end
  end

  // Pick the youngest valid producer of a register the EX instruction reads.
  function automatic logic [1:0] fwdSelect(input logic re, input logic [ADDR_W-1:0] ra,
                                           input logic exV,
                                           input logic memV, input logic memRw,
                                           input logic [ADDR_W-1:0] memWa,
                                           input logic wbV, input logic wbRw,
                                           input logic [ADDR_W-1:0] wbWa);
    logic [1:0] sel;
    sel = 2'b00;
    if (exV & re) begin
      if (memV & memRw & (memWa == ra))     sel = 2'b01;
      else if (wbV & wbRw & (wbWa == ra))   sel = 2'b10;
    end
    return sel;
  endfunction

  // Forwarding selects depend only on slot contents, never on stall state.
  always_comb begin
    fwdA = fwdSelect(exRe1_q, exRa1_q, exValid_q, memValid_q, memRegWrite_q, memWa_q,
                     wbValid_q, wbRegWrite_q, wbWa_q);
    fwdB = fwdSelect(exRe2_q, exRa2_q, exValid_q, memValid_q, memRegWrite_q, memWa_q,
                     wbValid_q, wbRegWrite_q, wbWa_q);
  end

  // Reset forces the pipeline closed regardless of slot state.
  assign PC_EN       = pcEn & ~RST;
  assign IFID_EN     = ifidEn & ~RST;
  assign IFID_FLUSH  = ifidFlush | RST;
  assign IDEX_BUBBLE = idexBubble | RST;
  assign FWD_A       = RST ? 2'b00 : fwdA;
  assign FWD_B       = RST ? 2'b00 : fwdB;

  // Shadow slots advance with the pipeline and hold while memory is busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exValid_q     <= 1'b0;
      exRegWrite_q  <= 1'b0;
      exMemRead_q   <= 1'b0;
      exRe1_q       <= 1'b0;
      exRe2_q       <= 1'b0;
      exWa_q        <= '0;
      exRa1_q       <= '0;
      exRa2_q       <= '0;
      memValid_q    <= 1'b0;
      memRegWrite_q <= 1'b0;
      memWa_q       <= '0;
      wbValid_q     <= 1'b0;
      wbRegWrite_q  <= 1'b0;
      wbWa_q        <= '0;
    end else if (!MEM_BUSY) begin
      wbValid_q     <= memValid_q;
      wbRegWrite_q  <= memRegWrite_q;
      wbWa_q        <= memWa_q;
      memValid_q    <= exValid_q;
      memRegWrite_q <= exRegWrite_q;
      memWa_q       <= exWa_q;
      exValid_q     <= ID_VALID & ~idexBubble;
      exRegWrite_q  <= ID_RegWrite;
      exMemRead_q   <= ID_MemRead;
      exRe1_q       <= ID_RE1;
      exRe2_q       <= ID_RE2;
      exWa_q        <= ID_WA;
      exRa1_q       <= ID_RA1;
      exRa2_q       <= ID_RA2;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

  // Count stalls and redirects actually taken, saturating at all-ones.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (!MEM_BUSY && !BR_TAKEN && loadUse && (stallCnt_q != '1))
      stallCnt_d = stallCnt_q + CntOne;
    if (!MEM_BUSY && BR_TAKEN && (flushCnt_q != '1))
      flushCnt_d = flushCnt_q + CntOne;
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign STALL_CNT = stallCnt_q;
  assign FLUSH_CNT = flushCnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// Expected control/forward values are queued with each stimulus step and
// popped when the outputs are sampled mid-cycle.
module tb_hazard_ctrl;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ID_VALID, ID_RE1, ID_RE2, ID_RegWrite, ID_MemRead;
  logic [ADDR_W-1:0] ID_RA1, ID_RA2, ID_WA;
  logic              BR_TAKEN, MEM_BUSY;
  logic              PC_EN, IFID_EN, IFID_FLUSH, IDEX_BUBBLE;
  logic [1:0]        FWD_A, FWD_B;
  logic [CNT_W-1:0]  STALL_CNT, FLUSH_CNT;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       flush;
    logic       bubble;
    logic [1:0] fa;
    logic [1:0] fb;
  } expT;

  expT   expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    errors = 0;
  int    stallEvents = 0;
  int    flushEvents = 0;
  logic  exIsLoad = 1'b0;
  logic  memIsLoad = 1'b0;

  hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .ID_VALID(ID_VALID), .ID_RE1(ID_RE1), .ID_RE2(ID_RE2),
    .ID_RA1(ID_RA1), .ID_RA2(ID_RA2),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_WA(ID_WA),
    .BR_TAKEN(BR_TAKEN), .MEM_BUSY(MEM_BUSY),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_FLUSH(IFID_FLUSH), .IDEX_BUBBLE(IDEX_BUBBLE),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string tag, input string name,
                         input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic pushExpect(input string tag, input logic pc, ifid, flush, bubble,
                            input logic [1:0] fa, fb);
    expT e;
    e = '{pc: pc, ifid: ifid, flush: flush, bubble: bubble, fa: fa, fb: fb};
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    expT   e;
    string tag;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard empty got 0 entries expected 1");
    end
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      compare(tag, "PC_EN", CNT_W'(PC_EN), CNT_W'(e.pc));
      compare(tag, "IFID_EN", CNT_W'(IFID_EN), CNT_W'(e.ifid));
      compare(tag, "IFID_FLUSH", CNT_W'(IFID_FLUSH), CNT_W'(e.flush));
      compare(tag, "IDEX_BUBBLE", CNT_W'(IDEX_BUBBLE), CNT_W'(e.bubble));
      compare(tag, "FWD_A", CNT_W'(FWD_A), CNT_W'(e.fa));
      compare(tag, "FWD_B", CNT_W'(FWD_B), CNT_W'(e.fb));
      checks++;
      assert (!(memIsLoad && (FWD_A === 2'b01 || FWD_B === 2'b01))) else begin
        errors++;
        $error("[TB] FAIL %s.loadFwdFromMem got fwd %0h/%0h expected no MEM select", tag, FWD_A, FWD_B);
      end
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef HAZARD_PERF_EN
    compare(tag, "STALL_CNT", STALL_CNT, CNT_W'(stallEvents));
    compare(tag, "FLUSH_CNT", FLUSH_CNT, CNT_W'(flushEvents));
`else
    compare(tag, "STALL_CNT", STALL_CNT, '0);
    compare(tag, "FLUSH_CNT", FLUSH_CNT, '0);
`endif
  endtask

  task automatic applyStimulus(input logic v, re1, re2, input logic [4:0] ra1, ra2,
                               input logic rw, mr, input logic [4:0] wa,
                               input logic br, busy);
    ID_VALID = v;  ID_RE1 = re1; ID_RE2 = re2; ID_RA1 = ra1; ID_RA2 = ra2;
    ID_RegWrite = rw; ID_MemRead = mr; ID_WA = wa;
    BR_TAKEN = br; MEM_BUSY = busy;
  endtask

  // One pipeline cycle: drive, queue expectation, sample at negedge, clock it in.
  task automatic step(input string tag,
                      input logic v, re1, re2, input logic [4:0] ra1, ra2,
                      input logic rw, mr, input logic [4:0] wa, input logic br, busy,
                      input logic pc, ifid, flush, bubble, input logic [1:0] fa, fb);
    applyStimulus(v, re1, re2, ra1, ra2, rw, mr, wa, br, busy);
    pushExpect(tag, pc, ifid, flush, bubble, fa, fb);
    @(negedge CLK);
    checkOutput();
    @(posedge CLK);
    if (!busy) begin
      memIsLoad = exIsLoad;
      exIsLoad  = v & mr & rw & ~bubble;
    end
    #1;
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    $display("[TB] reset state");
    pushExpect("reset", 0, 0, 1, 1, 2'b00, 2'b00);
    checkOutput();
    checkCounters("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("[TB] load-use stall");
    //   tag      v re1 re2 ra1 ra2 rw mr wa br bsy  pc if fl bu fa     fb
    step("ldR3",   1, 1, 0,  1,  0, 1, 1, 3, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("luStall",1, 1, 1,  3,  2, 1, 0, 4, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00);
    stallEvents++;
    step("luResume",1,1, 1,  3,  2, 1, 0, 4, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("luFwdWb",0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b10, 2'b00);
    checkCounters("afterLu");

    $display("[TB] back-to-back and one-apart forwarding");
    step("addR5",  1, 1, 1,  1,  2, 1, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("subR5",  1, 1, 1,  5,  7, 1, 0, 6, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("fwdMem", 0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b01, 2'b00);
    step("addR5b", 1, 1, 1,  1,  2, 1, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("indepR8",1, 1, 1,  1,  2, 1, 0, 8, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("subR5b", 1, 1, 1,  5,  7, 1, 0, 9, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("fwdWb",  0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b10, 2'b00);

    $display("[TB] MEM over WB priority and RE gating");
    step("addR5c", 1, 1, 1,  1,  2, 1, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("addR5d", 1, 1, 1,  1,  2, 1, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("stRcR5", 1, 1, 1,  1,  5, 0, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("fwdBMem",1, 0, 0,  5,  5, 1, 0,10, 0, 0,  1, 1, 0, 0, 2'b00, 2'b01);
    step("reGated",0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);

    $display("[TB] branch taken during load-use");
    step("ldR3b",  1, 1, 0,  1,  0, 1, 1, 3, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("brOverLu",1,1, 1,  3,  2, 1, 0, 4, 1, 0,  1, 1, 1, 1, 2'b00, 2'b00);
    flushEvents++;
    step("postBr", 0, 0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    checkCounters("afterBr");

    $display("[TB] memory busy freeze with pending branch");
    step("addR5e", 1, 1, 1,  1,  2, 1, 0, 5, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("subR5e", 1, 1, 1,  5,  7, 1, 0, 6, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("busy1",  1, 1, 1,  1,  2, 1, 0,11, 1, 1,  0, 0, 0, 0, 2'b01, 2'b00);
    step("busy2",  1, 1, 1,  1,  2, 1, 0,11, 1, 1,  0, 0, 0, 0, 2'b01, 2'b00);
    step("busy3",  1, 1, 1,  1,  2, 1, 0,11, 1, 1,  0, 0, 0, 0, 2'b01, 2'b00);
    step("busyRel",1, 1, 1,  1,  2, 1, 0,11, 1, 0,  1, 1, 1, 1, 2'b01, 2'b00);
    flushEvents++;
    step("flushOnce",0,0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    checkCounters("afterBusy");

    $display("[TB] asynchronous reset mid-stream");
    step("fillA",  1, 1, 1,  1,  2, 1, 0,12, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("fillB",  1, 1, 1, 12,  2, 1, 0,13, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("fillC",  1, 1, 1, 12, 13, 1, 0,14, 0, 0,  1, 1, 0, 0, 2'b01, 2'b00);
    step("fullPipe",1,1, 1,  1,  2, 1, 0,15, 0, 0,  1, 1, 0, 0, 2'b10, 2'b01);
    RST = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exIsLoad = 1'b0;
    memIsLoad = 1'b0;
    stallEvents = 0;
    flushEvents = 0;
    #1;
    pushExpect("midReset", 0, 0, 1, 1, 2'b00, 2'b00);
    checkOutput();
    checkCounters("midReset");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    pushExpect("released", 1, 1, 0, 0, 2'b00, 2'b00);
    checkOutput();
    @(posedge CLK);
    #1;

    $display("[TB] load-use after reset");
    step("ldR3c",  1, 1, 0,  1,  0, 1, 1, 3, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    step("luStall2",1,0, 1,  0,  3, 1, 0, 4, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00);
    stallEvents++;
    step("luResume2",1,0,1,  0,  3, 1, 0, 4, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00);
    checkCounters("afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
